uart_tx_buf: RTL and testbench

Buffered UART transmitter. It accepts bytes over a valid/ready handshake into a small FIFO and serialises each byte as 8N1: one start bit, 8 data bits LSB first, one stop bit, no parity. It is the transmit end of the UART link used by the test and demo harness, pairing with the design's 8N1 receiver at the same `CLKS_PER_BIT`. The FIFO lets a host burst several bytes without waiting for each frame to finish.

---
 rtl/uart_tx_buf_if.sv | 35 +++
 rtl/uart_tx_buf.sv | 224 ++++++++++++++++++++++
 tb/tb_uart_tx_buf.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_buf_if.sv
// -----------------------------------------------------------------------------
// uart_tx_buf_if
//   Byte-push handshake between a host and the buffered UART transmitter.
//
//   Signals:
//     i_Tx_DV     host -> tx   byte-valid strobe
//     i_Tx_Byte   host -> tx   byte to send
//     o_Tx_Ready  tx -> host   transmitter FIFO has room
//
//   Handshake: a byte is transferred on every rising clock edge where
//   i_Tx_DV && o_Tx_Ready. o_Tx_Ready does not depend on i_Tx_DV. If
//   i_Tx_DV is high while o_Tx_Ready is low, the byte is silently dropped;
//   the host is expected to watch o_Tx_Ready and hold off instead.
//
//   Modports:
//     master  host side (drives DV/Byte, observes Ready)
//     slave   transmitter side
// -----------------------------------------------------------------------------
interface uart_tx_buf_if;
  logic       i_Tx_DV;
  logic [7:0] i_Tx_Byte;
  logic       o_Tx_Ready;

  modport master (
    output i_Tx_DV,
    output i_Tx_Byte,
    input  o_Tx_Ready
  );

  modport slave (
    input  i_Tx_DV,
    input  i_Tx_Byte,
    output o_Tx_Ready
  );
endinterface

// File: rtl/uart_tx_buf.sv
// -----------------------------------------------------------------------------
// uart_tx_buf
//   Buffered 8N1 UART transmitter. Bytes pushed over the tx_if handshake are
//   queued in a small circular FIFO and serialised one at a time: start bit
//   (0), 8 data bits LSB first, stop bit (1). Back-to-back queued bytes are
//   separated by exactly one idle (high) cycle.
//
//   Parameters:
//     CLKS_PER_BIT  clock cycles per UART bit (f_clk / baud), >= 2
//     FIFO_DEPTH    byte FIFO depth, power of two, >= 2
//
//   Ports:
//     i_Clock       single clock, rising edge
//     i_Rst_n       asynchronous active-low reset; aborts any frame in
//                   progress and discards the FIFO contents
//     tx_if         byte-push handshake (slave modport)
//     o_Tx_Serial   serial line, registered, idles high
//     o_Tx_Active   high while a frame (start..stop) is on the line
//     o_Tx_Done     one-cycle pulse in the cycle after each stop bit
//     o_Fifo_Count  bytes waiting in the FIFO (not the one being shifted)
//     o_State       current FSM state (0 IDLE, 1 START, 2 DATA, 3 STOP)
// -----------------------------------------------------------------------------
module uart_tx_buf #(
  parameter int CLKS_PER_BIT = 87,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                        i_Clock,
  input  logic                        i_Rst_n,
  uart_tx_buf_if.slave                tx_if,
  output logic                        o_Tx_Serial,
  output logic                        o_Tx_Active,
  output logic                        o_Tx_Done,
  output logic [$clog2(FIFO_DEPTH):0] o_Fifo_Count,
  output logic [1:0]                  o_State
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);
  localparam logic [31:0]   LAST_CLK   = 32'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } state_t;

  // ---------------------------------------------------------------------------
  // FIFO
  // ---------------------------------------------------------------------------
  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          push;
  logic          pop;

  // Ready comes only from the count register, so a pop in the same cycle as
  // a full FIFO cannot open a slot for a push in that cycle.
  assign tx_if.o_Tx_Ready = (count_q != FULL_COUNT);
  assign push             = tx_if.i_Tx_DV && tx_if.o_Tx_Ready;

  // Storage needs no reset: a slot is only ever read after being written.
  always_ff @(posedge i_Clock) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= tx_if.i_Tx_Byte;
    end
  end

  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      // Pointers wrap naturally because the depth is a power of two.
      if (push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Serialiser FSM
  // ---------------------------------------------------------------------------
  state_t      state_q;
  state_t      state_d;
  logic [31:0] clk_cnt_q;
  logic [31:0] clk_cnt_d;
  logic [2:0]  bit_idx_q;
  logic [2:0]  bit_idx_d;
  logic [7:0]  shift_q;
  logic [7:0]  shift_d;
  logic        serial_q;
  logic        serial_d;
  logic        done_q;
  logic        done_d;
  logic        bit_done;
  logic        fifo_has_data;

  assign bit_done      = (clk_cnt_q == LAST_CLK);
  assign fifo_has_data = (count_q != '0);

  // State register together with the datapath registers the FSM steers.
  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_q   <= ST_IDLE;
      clk_cnt_q <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      serial_q  <= 1'b1;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      clk_cnt_q <= clk_cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      serial_q  <= serial_d;
      done_q    <= done_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (fifo_has_data) begin
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (bit_done) begin
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (bit_done && (bit_idx_q == 3'd7)) begin
          state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        if (bit_done) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output / datapath logic. The line value is computed one cycle ahead and
  // registered, so each level appears on the edge that enters its bit period.
  always_comb begin
    pop       = 1'b0;
    clk_cnt_d = clk_cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    serial_d  = serial_q;
    done_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        serial_d = 1'b1;
        if (fifo_has_data) begin
          pop       = 1'b1;
          shift_d   = fifo_mem[rd_ptr_q];
          serial_d  = 1'b0;
          clk_cnt_d = '0;
        end
      end
      ST_START: begin
        if (bit_done) begin
          clk_cnt_d = '0;
          bit_idx_d = '0;
          serial_d  = shift_q[0];
        end else begin
          clk_cnt_d = clk_cnt_q + 32'd1;
        end
      end
      ST_DATA: begin
        if (bit_done) begin
          clk_cnt_d = '0;
          if (bit_idx_q != 3'd7) begin
            // Shift right so the next bit to send is always at shift_q[1].
            bit_idx_d = bit_idx_q + 3'd1;
            shift_d   = {1'b0, shift_q[7:1]};
            serial_d  = shift_q[1];
          end else begin
            serial_d = 1'b1;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + 32'd1;
        end
      end
      ST_STOP: begin
        if (bit_done) begin
          clk_cnt_d = '0;
          done_d    = 1'b1;
        end else begin
          clk_cnt_d = clk_cnt_q + 32'd1;
        end
      end
      default: begin
        serial_d  = 1'b1;
        clk_cnt_d = '0;
      end
    endcase
  end

  assign o_Tx_Serial  = serial_q;
  assign o_Tx_Active  = (state_q != ST_IDLE);
  assign o_Tx_Done    = done_q;
  assign o_Fifo_Count = count_q;
  assign o_State      = state_q;

endmodule

// File: tb/tb_uart_tx_buf.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_buf
//   Directed and randomized checks of uart_tx_buf with CLKS_PER_BIT=4 and
//   FIFO_DEPTH=4. A line monitor decodes 8N1 frames from o_Tx_Serial and
//   checks each byte against an expected-byte queue filled by the producer.
// -----------------------------------------------------------------------------
module tb_uart_tx_buf;
  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  localparam int FRAME = 10 * CPB;

  // ---------------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------------
  logic       i_Clock = 1'b0;
  logic       i_Rst_n = 1'b0;
  logic       o_Tx_Serial;
  logic       o_Tx_Active;
  logic       o_Tx_Done;
  logic [2:0] o_Fifo_Count;
  logic [1:0] dbg_state;
  int         cyc = 0;

  uart_tx_buf_if tx_if ();

  uart_tx_buf #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .i_Clock      (i_Clock),
    .i_Rst_n      (i_Rst_n),
    .tx_if        (tx_if),
    .o_Tx_Serial  (o_Tx_Serial),
    .o_Tx_Active  (o_Tx_Active),
    .o_Tx_Done    (o_Tx_Done),
    .o_Fifo_Count (o_Fifo_Count),
    .o_State      (dbg_state)
  );

  always #5 i_Clock = ~i_Clock;
  always @(posedge i_Clock) cyc <= cyc + 1;

  // ---------------------------------------------------------------------------
  // Scoreboard state
  // ---------------------------------------------------------------------------
  logic [7:0] exp_q[$];
  int         start_q[$];
  int         checks = 0;
  int         errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Line monitor: every sample of a frame must equal the first sample of its
  // bit period, the stop bit must be 1, o_Tx_Active must be high exactly
  // during frame cycles and o_Tx_Done must pulse in the cycle after a frame.
  // ---------------------------------------------------------------------------
  int          mon_k = -1;
  logic [9:0]  mon_bits = '0;
  logic        done_due = 1'b0;
  int          frames = 0;
  int          start_cyc = 0;
  logic [31:0] mon_exp;

  always @(negedge i_Clock) begin
    if (!i_Rst_n) begin
      mon_k    = -1;
      done_due = 1'b0;
    end
    check("mon_done", 32'(o_Tx_Done), 32'(done_due));
    done_due = 1'b0;
    if (i_Rst_n && mon_k < 0 && o_Tx_Serial === 1'b0) begin
      mon_k     = 0;
      start_cyc = cyc;
    end
    check("mon_active", 32'(o_Tx_Active), (mon_k >= 0) ? 32'd1 : 32'd0);
    if (mon_k >= 0) begin
      if (mon_k % CPB == 0) begin
        mon_bits[mon_k / CPB] = o_Tx_Serial;
      end else begin
        check("mon_bit_hold", 32'(o_Tx_Serial), 32'(mon_bits[mon_k / CPB]));
      end
      mon_k++;
      if (mon_k == FRAME) begin
        check("mon_stop_bit", 32'(mon_bits[9]), 32'd1);
        // 0x100 can never match a byte, so an unexpected frame fails.
        mon_exp = (exp_q.size() != 0) ? 32'(exp_q.pop_front()) : 32'h100;
        check("sb_byte", 32'(mon_bits[8:1]), mon_exp);
        start_q.push_back(start_cyc);
        frames++;
        done_due = 1'b1;
        mon_k    = -1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver helpers
  // ---------------------------------------------------------------------------
  task automatic wait_drain(input string tag, input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || mon_k >= 0 || o_Tx_Active) && n < budget) begin
      @(negedge i_Clock);
      n++;
    end
    check(tag, 32'(exp_q.size()), 32'd0);
    repeat (2) @(negedge i_Clock);
  endtask

  task automatic check_spacing(input string tag, input int first);
    for (int i = first + 1; i < start_q.size(); i++) begin
      check(tag, 32'(start_q[i] - start_q[i-1]), 32'(FRAME + 1));
    end
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  int s0;
  int f0;
  int px;
  int sent;
  int budget;
  logic [7:0] rb;

  initial begin
    tx_if.i_Tx_DV   = 1'b0;
    tx_if.i_Tx_Byte = 8'h00;
    i_Rst_n         = 1'b0;
    repeat (3) @(negedge i_Clock);
    i_Rst_n = 1'b1;
    @(negedge i_Clock);

    // Reset values
    check("rst_serial", 32'(o_Tx_Serial), 32'd1);
    check("rst_ready",  32'(tx_if.o_Tx_Ready), 32'd1);
    check("rst_count",  32'(o_Fifo_Count), 32'd0);
    check("rst_active", 32'(o_Tx_Active), 32'd0);
    check("rst_done",   32'(o_Tx_Done), 32'd0);

    // Single byte 0xA5: start bit one cycle after the push edge
    s0 = start_q.size();
    tx_if.i_Tx_DV   = 1'b1;
    tx_if.i_Tx_Byte = 8'hA5;
    exp_q.push_back(8'hA5);
    @(negedge i_Clock);
    tx_if.i_Tx_DV = 1'b0;
    px = cyc;
    check("single_count", 32'(o_Fifo_Count), 32'd1);
    wait_drain("single_drain", 200);
    check("single_frames", 32'(start_q.size() - s0), 32'd1);
    if (start_q.size() > s0) check("single_latency", 32'(start_q[s0] - px), 32'd1);

    // Burst to full: 0x01..0x05 accepted, 0x06 dropped
    s0 = start_q.size();
    for (int i = 1; i <= 5; i++) begin
      check("burst_ready", 32'(tx_if.o_Tx_Ready), 32'd1);
      tx_if.i_Tx_DV   = 1'b1;
      tx_if.i_Tx_Byte = 8'(i);
      exp_q.push_back(8'(i));
      @(negedge i_Clock);
    end
    check("burst_full_ready", 32'(tx_if.o_Tx_Ready), 32'd0);
    check("burst_full_count", 32'(o_Fifo_Count), 32'(DEPTH));
    tx_if.i_Tx_Byte = 8'h06;
    @(negedge i_Clock);
    tx_if.i_Tx_DV = 1'b0;
    check("burst_drop_count", 32'(o_Fifo_Count), 32'(DEPTH));
    wait_drain("burst_drain", 5 * (FRAME + 1) + 100);
    check("burst_frames", 32'(start_q.size() - s0), 32'd5);
    check_spacing("burst_spacing", s0);

    // Simultaneous push and pop with count=1
    s0 = start_q.size();
    tx_if.i_Tx_DV   = 1'b1;
    tx_if.i_Tx_Byte = 8'h3C;
    exp_q.push_back(8'h3C);
    @(negedge i_Clock);
    px = cyc;
    tx_if.i_Tx_Byte = 8'hC3;              // lands on the 0x3C pop edge
    exp_q.push_back(8'hC3);
    @(negedge i_Clock);
    tx_if.i_Tx_DV = 1'b0;
    check("simul_count_a", 32'(o_Fifo_Count), 32'd1);
    // The IDLE cycle after the 0x3C frame is FRAME+1 cycles after its push.
    while (cyc < px + FRAME + 1) @(negedge i_Clock);
    check("simul_idle_count", 32'(o_Fifo_Count), 32'd1);
    tx_if.i_Tx_DV   = 1'b1;
    tx_if.i_Tx_Byte = 8'h96;              // lands on the 0xC3 pop edge
    exp_q.push_back(8'h96);
    @(negedge i_Clock);
    tx_if.i_Tx_DV = 1'b0;
    check("simul_count_b", 32'(o_Fifo_Count), 32'd1);
    wait_drain("simul_drain", 3 * (FRAME + 1) + 100);
    check("simul_frames", 32'(start_q.size() - s0), 32'd3);
    check_spacing("simul_spacing", s0);

    // Mid-frame reset with two bytes queued
    for (int i = 0; i < 3; i++) begin
      tx_if.i_Tx_DV   = 1'b1;
      tx_if.i_Tx_Byte = 8'h70 + 8'(i);
      exp_q.push_back(8'h70 + 8'(i));
      @(negedge i_Clock);
    end
    tx_if.i_Tx_DV = 1'b0;
    check("mrst_queued", 32'(o_Fifo_Count), 32'd2);
    repeat (15) @(negedge i_Clock);
    check("mrst_pre_active", 32'(o_Tx_Active), 32'd1);
    #2 i_Rst_n = 1'b0;
    #1;
    check("mrst_serial", 32'(o_Tx_Serial), 32'd1);
    check("mrst_count",  32'(o_Fifo_Count), 32'd0);
    check("mrst_active", 32'(o_Tx_Active), 32'd0);
    check("mrst_ready",  32'(tx_if.o_Tx_Ready), 32'd1);
    exp_q.delete();
    f0 = frames;
    repeat (3) @(negedge i_Clock);
    i_Rst_n = 1'b1;
    repeat (100) @(negedge i_Clock);
    check("mrst_no_frame", 32'(frames - f0), 32'd0);
    check("mrst_count_after", 32'(o_Fifo_Count), 32'd0);
    check("mrst_serial_after", 32'(o_Tx_Serial), 32'd1);

    // Pointer wrap: 3*DEPTH+1 random bytes, producer honours ready
    s0     = start_q.size();
    sent   = 0;
    budget = 0;
    while (sent < 3 * DEPTH + 1 && budget < 5000) begin
      if (tx_if.o_Tx_Ready && $urandom_range(0, 3) != 0) begin
        rb              = 8'($urandom);
        tx_if.i_Tx_DV   = 1'b1;
        tx_if.i_Tx_Byte = rb;
        exp_q.push_back(rb);
        sent++;
      end else begin
        tx_if.i_Tx_DV = 1'b0;
      end
      @(negedge i_Clock);
      budget++;
    end
    tx_if.i_Tx_DV = 1'b0;
    check("wrap_sent", 32'(sent), 32'(3 * DEPTH + 1));
    wait_drain("wrap_drain", (3 * DEPTH + 1) * (FRAME + 1) + 200);
    check("wrap_frames", 32'(start_q.size() - s0), 32'(3 * DEPTH + 1));
    check_spacing("wrap_spacing", s0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    errors++;
    $display("FAIL timeout: observed no completion expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
